pattern_tx: RTL and testbench

//   Serial pattern transmitter: the source end of the 1-bit serial stream consumed by the
//   1101 sequence detector (mealy). On a start request, drives a fixed PAT_WIDTH-bit

---
 rtl/pattern_tx.sv | 148 ++++++++++++++
 tb/tb_pattern_tx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : pattern_tx
// Function : Serial pattern transmitter. Sends PATTERN MSB-first on o, repeated
//            N times with GAP_BITS zero bits between repeats, then pulses done.
//            Optional abort port is enabled by defining TX_ABORT_EN.
// Revision : 1.0
// ============================================================================
module pattern_tx #(
    parameter int                   PAT_WIDTH = 4,
    parameter logic [PAT_WIDTH-1:0] PATTERN   = 4'b1101,
    parameter int                   CNT_BITS  = 4,
    parameter int                   GAP_BITS  = 0
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [CNT_BITS-1:0] repeat_cnt,
`ifdef TX_ABORT_EN
    input  logic                abort,
`endif
    output logic                o,
    output logic                busy,
    output logic                done
);

    localparam int IDX_W = $clog2(PAT_WIDTH);
    localparam logic [IDX_W-1:0] c_idx_msb  = IDX_W'(PAT_WIDTH - 1);
    localparam logic [3:0]       c_gap_last = 4'((GAP_BITS > 0) ? (GAP_BITS - 1) : 0);
    localparam logic             c_pat_msb  = PATTERN[PAT_WIDTH-1];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t              r_state,    w_state_nxt;
    logic [IDX_W-1:0]    r_bit_idx,  w_idx_nxt;
    logic [CNT_BITS-1:0] r_rep_left, w_rep_nxt;
    logic [3:0]          r_gap_cnt,  w_gap_nxt;
    logic                r_o,        w_o_nxt;
    logic                r_busy,     w_busy_nxt;
    logic                r_done,     w_done_nxt;
    logic [IDX_W-1:0]    w_idx_dec;

    assign w_idx_dec = r_bit_idx - 1'b1;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= ST_IDLE;
            r_bit_idx  <= '0;
            r_rep_left <= '0;
            r_gap_cnt  <= '0;
            r_o        <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_idx  <= w_idx_nxt;
            r_rep_left <= w_rep_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_o        <= w_o_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_bit_idx;
        w_rep_nxt   = r_rep_left;
        w_gap_nxt   = r_gap_cnt;
        w_o_nxt     = r_o;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_o_nxt    = 1'b0;
                w_busy_nxt = 1'b0;
                if (start) begin
                    if (repeat_cnt == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_rep_nxt   = repeat_cnt;
                        w_idx_nxt   = c_idx_msb;
                        w_o_nxt     = c_pat_msb;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (r_bit_idx != '0) begin
                    w_idx_nxt = w_idx_dec;
                    w_o_nxt   = PATTERN[w_idx_dec];
                end else if (r_rep_left != CNT_BITS'(1)) begin
                    // LSB of a non-final repeat: either pad with zeros or restart at once
                    w_rep_nxt = r_rep_left - 1'b1;
                    if (GAP_BITS > 0) begin
                        w_o_nxt     = 1'b0;
                        w_gap_nxt   = c_gap_last;
                        w_state_nxt = ST_GAP;
                    end else begin
                        w_o_nxt   = c_pat_msb;
                        w_idx_nxt = c_idx_msb;
                    end
                end else begin
                    w_o_nxt     = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_o_nxt     = c_pat_msb;
                    w_idx_nxt   = c_idx_msb;
                    w_state_nxt = ST_SEND;
                end else begin
                    w_gap_nxt = r_gap_cnt - 1'b1;
                    w_o_nxt   = 1'b0;
                end
            end
            default: begin
                w_o_nxt     = 1'b0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase

`ifdef TX_ABORT_EN
        if (abort && r_busy) begin
            w_o_nxt     = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
        end
`endif
    end

    assign o    = r_o;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_tx
// Function : Directed self-checking bench for pattern_tx (one instance with
//            GAP_BITS=0, one with GAP_BITS=2).
// Revision : 1.0
// ============================================================================
module tb_pattern_tx;

    logic       tb_clk = 1'b0;
    logic       n_rst  = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [3:0] cnt_a   = 4'd0;
    logic [3:0] cnt_b   = 4'd0;
    logic       o_a, busy_a, done_a;
    logic       o_b, busy_b, done_b;
`ifdef TX_ABORT_EN
    logic       abort_a = 1'b0;
    logic       abort_b = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 tb_clk = ~tb_clk;

    pattern_tx #(.PAT_WIDTH(4), .PATTERN(4'b1101), .CNT_BITS(4), .GAP_BITS(0)) u_dut_a (
        .clk        (tb_clk),
        .n_rst      (n_rst),
        .start      (start_a),
        .repeat_cnt (cnt_a),
`ifdef TX_ABORT_EN
        .abort      (abort_a),
`endif
        .o          (o_a),
        .busy       (busy_a),
        .done       (done_a)
    );

    pattern_tx #(.PAT_WIDTH(4), .PATTERN(4'b1101), .CNT_BITS(4), .GAP_BITS(2)) u_dut_b (
        .clk        (tb_clk),
        .n_rst      (n_rst),
        .start      (start_b),
        .repeat_cnt (cnt_b),
`ifdef TX_ABORT_EN
        .abort      (abort_b),
`endif
        .o          (o_b),
        .busy       (busy_b),
        .done       (done_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] exp_gap;
        logic [7:0] exp_lb;
        logic [3:0] sh;
        logic [7:0] hits;
        int         n;

        exp_gap = 10'b11_0100_1101;
        exp_lb  = 8'b1101_1101;

        // reset state
        #1 n_rst = 1'b0;
        #1;
        check_val("rst_o_a",    32'(o_a),    32'd0);
        check_val("rst_busy_a", 32'(busy_a), 32'd0);
        check_val("rst_done_a", 32'(done_a), 32'd0);
        check_val("rst_o_b",    32'(o_b),    32'd0);
        tick();
        tick();
        n_rst = 1'b1;
        tick();

        // N=2 with two gap bits
        start_b = 1'b1;
        cnt_b   = 4'd2;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_val("gap_o",    32'(o_b),    32'(exp_gap[9-i]));
            check_val("gap_busy", 32'(busy_b), 32'd1);
            check_val("gap_done", 32'(done_b), 32'd0);
            tick();
        end
        check_val("gap_end_done", 32'(done_b), 32'd1);
        check_val("gap_end_busy", 32'(busy_b), 32'd0);
        check_val("gap_end_o",    32'(o_b),    32'd0);
        tick();
        check_val("gap_done_pulse", 32'(done_b), 32'd0);

        // N=0: done only
        start_a = 1'b1;
        cnt_a   = 4'd0;
        tick();
        start_a = 1'b0;
        check_val("n0_done", 32'(done_a), 32'd1);
        check_val("n0_busy", 32'(busy_a), 32'd0);
        check_val("n0_o",    32'(o_a),    32'd0);
        tick();
        check_val("n0_done_low", 32'(done_a), 32'd0);
        check_val("n0_busy_low", 32'(busy_a), 32'd0);

        // N=2 back-to-back, 1101 occurrences in the stream
        start_a = 1'b1;
        cnt_a   = 4'd2;
        tick();
        start_a = 1'b0;
        sh   = 4'd0;
        hits = 8'd0;
        for (int i = 0; i < 8; i++) begin
            check_val("lb_o", 32'(o_a), 32'(exp_lb[7-i]));
            sh = {sh[2:0], o_a};
            if (sh == 4'b1101) hits[i] = 1'b1;
            tick();
        end
        check_val("lb_hits", 32'(hits),   32'h88);
        check_val("lb_done", 32'(done_a), 32'd1);
        tick();

        // start while busy ignored, start on done cycle accepted
        start_a = 1'b1;
        cnt_a   = 4'd1;
        tick();
        start_a = 1'b0;
        check_val("rs_b0", 32'(o_a), 32'd1);
        tick();
        check_val("rs_b1", 32'(o_a), 32'd1);
        start_a = 1'b1;
        cnt_a   = 4'd3;
        tick();
        start_a = 1'b0;
        check_val("rs_b2",      32'(o_a),    32'd0);
        check_val("rs_b2_busy", 32'(busy_a), 32'd1);
        tick();
        check_val("rs_b3", 32'(o_a), 32'd1);
        tick();
        check_val("rs_done", 32'(done_a), 32'd1);
        check_val("rs_busy", 32'(busy_a), 32'd0);
        start_a = 1'b1;
        cnt_a   = 4'd1;
        tick();
        start_a = 1'b0;
        check_val("rs2_b0",   32'(o_a),    32'd1);
        check_val("rs2_busy", 32'(busy_a), 32'd1);
        check_val("rs2_done", 32'(done_a), 32'd0);
        tick();
        check_val("rs2_b1", 32'(o_a), 32'd1);
        tick();
        check_val("rs2_b2", 32'(o_a), 32'd0);
        tick();
        check_val("rs2_b3", 32'(o_a), 32'd1);
        tick();
        check_val("rs2_end_done", 32'(done_a), 32'd1);
        tick();

        // maximum repeat count, no wrap
        start_a = 1'b1;
        cnt_a   = 4'd15;
        tick();
        start_a = 1'b0;
        n = 0;
        while (busy_a && n < 100) begin
            n++;
            tick();
        end
        check_val("max_busy_cycles", 32'(n),      32'd60);
        check_val("max_done",        32'(done_a), 32'd1);
        tick();

        // async reset mid-transmission
        start_a = 1'b1;
        cnt_a   = 4'd3;
        tick();
        start_a = 1'b0;
        tick();
        tick();
        check_val("ar_busy_before", 32'(busy_a), 32'd1);
        #2 n_rst = 1'b0;
        #1;
        check_val("ar_o",    32'(o_a),    32'd0);
        check_val("ar_busy", 32'(busy_a), 32'd0);
        check_val("ar_done", 32'(done_a), 32'd0);
        tick();
        check_val("ar_no_done", 32'(done_a), 32'd0);
        n_rst = 1'b1;
        tick();
        check_val("ar_idle_busy", 32'(busy_a), 32'd0);
        check_val("ar_idle_done", 32'(done_a), 32'd0);

`ifdef TX_ABORT_EN
        // abort in idle has no effect
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check_val("ab_idle_done", 32'(done_a), 32'd0);
        check_val("ab_idle_busy", 32'(busy_a), 32'd0);
        // abort on bit 6 of N=3
        start_a = 1'b1;
        cnt_a   = 4'd3;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_val("ab_b6", 32'(o_a), 32'd1);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check_val("ab_o",    32'(o_a),    32'd0);
        check_val("ab_busy", 32'(busy_a), 32'd0);
        check_val("ab_done", 32'(done_a), 32'd1);
        start_a = 1'b1;
        cnt_a   = 4'd1;
        tick();
        start_a = 1'b0;
        check_val("ab_restart_o",    32'(o_a),    32'd1);
        check_val("ab_restart_busy", 32'(busy_a), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        check_val("ab_restart_done", 32'(done_a), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
